// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding CPU access (byte/half/word), sub-word stores via read-modify-write.
// Build option LSU_MISALIGN_TRAP_EN: misaligned requests report respErr instead of being force-aligned.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqStore,
  input  logic [1:0]        reqSize,
  input  logic              reqSigned,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [31:0]       reqWData,
  output logic              respValid,
  output logic              respErr,
  output logic [31:0]       respRData,
  output logic [31:0]       memAddress,
  output logic [31:0]       memWriteData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [31:0]       memReadData,
  output logic [2:0]        dbgState
);

  // Handshake: a request is taken on the posedge where reqValid && reqReady; reqReady is high
  // only in IDLE. respValid is a single-cycle pulse with no backpressure.
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] READ      = 3'd1;
  localparam logic [2:0] RMW_READ  = 3'd2;
  localparam logic [2:0] RMW_WRITE = 3'd3;
  localparam logic [2:0] WRITE     = 3'd4;
  localparam logic [2:0] RESP      = 3'd5;

  logic [2:0] state;
  logic [1:0] size_q;
  logic [1:0] lane_q;
  logic       signed_q;

  logic       is_half;
  logic       is_word;
  logic [1:0] lane_in;
  logic       trap_hit;

  assign is_half = (reqSize == 2'b01);
  assign is_word = reqSize[1];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic err_q;

  assign misaligned = (is_half && reqAddr[0]) || (is_word && (reqAddr[1:0] != 2'b00));
  assign lane_in    = reqAddr[1:0];
  assign trap_hit   = misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && reqValid) begin
      err_q <= misaligned;
    end
  end

  assign respErr = err_q;
`else
  // Without the trap, misaligned requests silently drop the offending low address bits.
  assign lane_in  = is_word ? 2'b00 : (is_half ? {reqAddr[1], 1'b0} : reqAddr[1:0]);
  assign trap_hit = 1'b0;
  assign respErr  = 1'b0;
`endif

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge_sub(input logic [31:0] w, input logic [15:0] d,
                                            input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[{lane, 3'b000} +: 8] = d[7:0];
    else             r[{lane[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

  // memWriteData doubles as the store-data latch; RMW_READ overwrites it with the merged word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      signed_q     <= 1'b0;
      respRData    <= 32'h0;
      memAddress   <= 32'h0;
      memWriteData <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            size_q       <= reqSize;
            lane_q       <= lane_in;
            signed_q     <= reqSigned;
            memAddress   <= 32'(reqAddr[ADDR_W-1:2]);
            memWriteData <= reqWData;
            respRData    <= 32'h0;
            if (trap_hit)      state <= RESP;
            else if (!reqStore) state <= READ;
            else if (is_word)  state <= WRITE;
            else               state <= RMW_READ;
          end
        end
        READ: begin
          respRData <= load_extract(memReadData, size_q, lane_q, signed_q);
          state     <= RESP;
        end
        RMW_READ: begin
          memWriteData <= merge_sub(memReadData, memWriteData[15:0], size_q, lane_q);
          state        <= RMW_WRITE;
        end
        RMW_WRITE: state <= RESP;
        WRITE:     state <= RESP;
        RESP:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign reqReady  = (state == IDLE);
  assign memRead   = (state == READ) || (state == RMW_READ);
  assign memWrite  = (state == WRITE) || (state == RMW_WRITE);
  assign respValid = (state == RESP);
  assign dbgState  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus reset-abort and back-to-back sequences.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        reqStore;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        respValid;
  logic        respErr;
  logic [31:0] respRData;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData;
  logic [2:0]  dbgState;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqStore(reqStore), .reqSize(reqSize),
    .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWData(reqWData),
    .respValid(respValid), .respErr(respErr), .respRData(respRData),
    .memAddress(memAddress), .memWriteData(memWriteData), .memWrite(memWrite),
    .memRead(memRead), .memReadData(memReadData), .dbgState(dbgState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rd_word;
  int          rd_cnt;
  int          wr_cnt;
  logic [31:0] last_raddr;
  logic [31:0] last_waddr;
  logic        both_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: read word appears after the falling edge of a read cycle, junk otherwise.
  always @(negedge clk) memReadData <= memRead ? rd_word : 32'hA5A5_5A5A;

  // Monitor and write scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    if (memRead && memWrite) both_seen = 1'b1;
    if (memRead) begin
      rd_cnt++;
      last_raddr = memAddress;
    end
    if (memWrite) begin
      wr_cnt++;
      last_waddr = memAddress;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got data %h addr %h expected no write", memWriteData, memAddress);
      end else begin
        e = exp_q.pop_front();
        if (memWriteData !== e) begin
          n_fail++;
          $display("FAIL write_data: got %h expected %h", memWriteData, e);
        end
      end
    end
  end

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wword;
    logic [31:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic [1:0] sz, logic sg, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] mw, logic [31:0] rdat, logic er, int lat, int nrd,
                              int nwr, logic [31:0] ww, logic [31:0] idx);
    vec_t v;
    v.store = st; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd; v.mword = mw;
    v.exp_rdata = rdat; v.exp_err = er; v.exp_lat = lat; v.exp_rd = nrd; v.exp_wr = nwr;
    v.exp_wword = ww; v.exp_idx = idx;
    return v;
  endfunction

  // Driver: present one request at a negedge, release it after the accepting posedge,
  // then wait (bounded) for the response and check everything observed.
  task automatic run_vec(input int i, input vec_t v);
    int lat;
    @(negedge clk);
    check($sformatf("v%0d_ready", i), {31'b0, reqReady}, 32'h1);
    rd_word = v.mword; rd_cnt = 0; wr_cnt = 0;
    if (v.exp_wr != 0) exp_q.push_back(v.exp_wword);
    reqValid = 1'b1; reqStore = v.store; reqSize = v.size; reqSigned = v.sgn;
    reqAddr = v.addr; reqWData = v.wdata;
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (respValid) lat = k;
    end
    check($sformatf("v%0d_latency", i), lat, v.exp_lat);
    check($sformatf("v%0d_rdata", i), respRData, v.exp_rdata);
    check($sformatf("v%0d_err", i), {31'b0, respErr}, {31'b0, v.exp_err});
    check($sformatf("v%0d_reads", i), rd_cnt, v.exp_rd);
    check($sformatf("v%0d_writes", i), wr_cnt, v.exp_wr);
    if (v.exp_rd != 0) check($sformatf("v%0d_raddr", i), last_raddr, v.exp_idx);
    if (v.exp_wr != 0) check($sformatf("v%0d_waddr", i), last_waddr, v.exp_idx);
  endtask

  initial begin
    int resp_seen;
    int first_resp;
    int second_resp;
    int ready_k;

    rst = 1'b0; reqValid = 1'b0; reqStore = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = 32'h0; reqWData = 32'h0; rd_word = 32'h0; rd_cnt = 0; wr_cnt = 0;
    last_raddr = 32'h0; last_waddr = 32'h0; both_seen = 1'b0;

    // Vector table: store, size, signed, addr, wdata, memword, rdata, err, lat, reads, writes, wword, index
    vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0,        0, 2, 0, 1, 32'hDEADBEEF, 32'd4));
    vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0,        32'h80FF7F01, 32'hFFFFFF80, 0, 2, 1, 0, 32'h0,        32'd4));
    vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0,        32'h80FF7F01, 32'h00000080, 0, 2, 1, 0, 32'h0,        32'd4));
    vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'h000000AA, 32'h11223344, 32'h0,        0, 3, 1, 1, 32'h1122AA44, 32'd4));
    vecs.push_back(mk(0, 2'b01, 1, 32'h06, 32'h0,        32'h9ABC0000, 32'hFFFF9ABC, 0, 2, 1, 0, 32'h0,        32'd1));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0C, 32'h12345678, 32'hFFFFFFFF, 32'h0,        0, 3, 1, 1, 32'hFFFF5678, 32'd3));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0E, 32'h0000CAFE, 32'h00001111, 32'h0,        0, 3, 1, 1, 32'hCAFE1111, 32'd3));
    vecs.push_back(mk(0, 2'b11, 1, 32'h20, 32'h0,        32'h12345678, 32'h12345678, 0, 2, 1, 0, 32'h0,        32'd8));
    vecs.push_back(mk(0, 2'b00, 1, 32'h00, 32'h0,        32'h000000FE, 32'hFFFFFFFE, 0, 2, 1, 0, 32'h0,        32'd0));
    vecs.push_back(mk(1, 2'b00, 1, 32'h3F, 32'h00000077, 32'h00000000, 32'h0,        0, 3, 1, 1, 32'h77000000, 32'd15));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 2'b01, 0, 32'h03, 32'h0,        32'h80011234, 32'h0,        1, 1, 0, 0, 32'h0,        32'd0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h21, 32'h0,        32'h55AA55AA, 32'h0,        1, 1, 0, 0, 32'h0,        32'd8));
    vecs.push_back(mk(1, 2'b10, 0, 32'h1A, 32'h01020304, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        32'd6));
`else
    vecs.push_back(mk(0, 2'b01, 0, 32'h03, 32'h0,        32'h80011234, 32'h00008001, 0, 2, 1, 0, 32'h0,        32'd0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h21, 32'h0,        32'h55AA55AA, 32'h55AA55AA, 0, 2, 1, 0, 32'h0,        32'd8));
    vecs.push_back(mk(1, 2'b10, 0, 32'h1A, 32'h01020304, 32'h0,        32'h0,        0, 2, 0, 1, 32'h01020304, 32'd6));
`endif

    // Reset state
    #12;
    check("rst_ready", {31'b0, reqReady}, 32'h1);
    check("rst_state", {29'b0, dbgState}, 32'h0);
    check("rst_strobes", {30'b0, memRead, memWrite}, 32'h0);
    check("rst_resp", {30'b0, respValid, respErr}, 32'h0);
    check("rst_rdata", respRData, 32'h0);
    check("rst_maddr", memAddress, 32'h0);
    check("rst_mwdata", memWriteData, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted mid read-modify-write: access aborted, no write afterwards
    @(negedge clk);
    rd_word = 32'h11223344; rd_cnt = 0; wr_cnt = 0;
    reqValid = 1'b1; reqStore = 1'b1; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = 32'h11; reqWData = 32'h000000AA;
    @(posedge clk);
    #1 reqValid = 1'b0;
    check("abort_in_rmw_read", {31'b0, memRead}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("abort_strobes", {30'b0, memRead, memWrite}, 32'h0);
    check("abort_state", {29'b0, dbgState}, 32'h0);
    check("abort_resp", {31'b0, respValid}, 32'h0);
    check("abort_maddr", memAddress, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    resp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (respValid) resp_seen++;
    end
    check("abort_no_resp", resp_seen, 0);
    check("abort_no_write", wr_cnt, 0);
    check("abort_ready", {31'b0, reqReady}, 32'h1);

    // Back-to-back: word store then load, reqValid held high throughout
    @(negedge clk);
    exp_q.push_back(32'hCAFEF00D);
    reqValid = 1'b1; reqStore = 1'b1; reqSize = 2'b10; reqSigned = 1'b0;
    reqAddr = 32'h24; reqWData = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    rd_word = 32'h0BADBEEF;
    reqStore = 1'b0; reqAddr = 32'h28; reqWData = 32'h0;
    first_resp = 0; second_resp = 0; ready_k = 0;
    for (int k = 1; k <= 12 && second_resp == 0; k++) begin
      @(negedge clk);
      if (reqReady && ready_k == 0) ready_k = k;
      if (respValid) begin
        if (first_resp == 0) first_resp = k;
        else begin
          second_resp = k;
          reqValid = 1'b0;
        end
      end
    end
    reqValid = 1'b0;
    check("b2b_first_resp", first_resp, 2);
    check("b2b_second_accept", ready_k, 3);
    check("b2b_second_resp", second_resp, 5);
    check("b2b_load_data", respRData, 32'h0BADBEEF);

    repeat (2) @(negedge clk);
    check("no_overlap_strobes", {31'b0, both_seen}, 32'h0);
    check("writes_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
